// File: rtl/lane_departure_monitor_if.sv
// Decision-result bus from the lane-detection stage into the departure monitor.
// master drives a result; slave (the monitor) samples it.
interface lane_departure_monitor_if #(
  parameter int BW = 10
) ();
  logic          decision_out_valid;
  logic [3:0]    number_of_lanes;
  logic [3:0]    current_lane;
  logic [BW-1:0] current_lane_left_boundary;
  logic [BW-1:0] current_lane_right_boundary;

  modport master (
    output decision_out_valid, number_of_lanes, current_lane,
           current_lane_left_boundary, current_lane_right_boundary
  );

  modport slave (
    input  decision_out_valid, number_of_lanes, current_lane,
           current_lane_left_boundary, current_lane_right_boundary
  );
endinterface

// File: rtl/lane_departure_monitor.sv
// Lane departure monitor: sanity-checks each decision result, reports the car offset,
// debounces left/right departure warnings, flags lane changes and declares lane loss.
module lane_departure_monitor #(
  parameter int IMG_WIDTH      = 416,
  parameter int CAR_CENTER     = 208,
  parameter int WARN_MARGIN    = 40,
  parameter int MIN_LANE_WIDTH = 60,
  parameter int CONFIRM_FRAMES = 3,
  parameter int TIMEOUT_CYCLES = 2**20,
  localparam int BW            = $clog2(IMG_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lane_departure_monitor_if.slave  dec,
  output logic signed [BW:0]       lane_offset,
  output logic                     offset_valid,
  output logic                     departure_left,
  output logic                     departure_right,
  output logic                     lane_change,
  output logic                     lane_lost,
  output logic [2:0]               monitor_state
);

  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] CC      = BW'(CAR_CENTER);
  localparam logic [BW-1:0] MARGIN  = BW'(WARN_MARGIN);
  localparam logic [BW-1:0] MIN_W   = BW'(MIN_LANE_WIDTH);
  localparam logic [CW-1:0] CF      = CW'(CONFIRM_FRAMES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRACK  = 3'd1,
    WARN_L = 3'd2,
    WARN_R = 3'd3,
    LOST   = 3'd4
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CF) ? CF : c + CW'(1);
  endfunction

  // Stage 1: captured result
  logic          s1_valid;
  logic [3:0]    s1_lanes;
  logic [3:0]    s1_lane;
  logic [BW-1:0] s1_left;
  logic [BW-1:0] s1_right;

  // Stage 2: tracking state
  state_t        state;
  logic [CW-1:0] left_cnt, right_cnt, good_cnt, bad_cnt, clr_cnt;
  logic [WW-1:0] wd_cnt;
  logic [3:0]    last_lane;
  logic          have_lane;

  // Combinational decision
  logic [BW-1:0]      width;
  logic               good, bad;
  logic               near_l_raw, near_r_raw, near_left, near_right;
  logic               chg;
  logic [BW:0]        sum;
  logic [BW-1:0]      mid;
  logic signed [BW:0] offset;
  logic [CW-1:0]      n_left, n_right, n_good, n_bad, n_clr;
  state_t             state_base, state_next;
  logic               counting, wd_hit;

  // NOTE: synchronous reset also clears the stage-1 valid, so an in-flight result is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lanes <= '0;
      s1_lane  <= '0;
      s1_left  <= '0;
      s1_right <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      s1_valid <= dec.decision_out_valid;
      if (dec.decision_out_valid) begin
        s1_lanes <= dec.number_of_lanes;
        s1_lane  <= dec.current_lane;
        s1_left  <= dec.current_lane_left_boundary;
        s1_right <= dec.current_lane_right_boundary;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    width  = s1_right - s1_left;
    good   = s1_valid && (s1_lanes != 4'd0) && (s1_left < s1_right) && (width >= MIN_W)
             && (s1_left <= CC) && (CC <= s1_right);
    bad    = s1_valid && !good;

    // Near flags are only meaningful once the geometry passed the sanity check.
    near_l_raw = (CC - s1_left) < MARGIN;
    near_r_raw = (s1_right - CC) < MARGIN;
    near_left  = good && near_l_raw && !near_r_raw;
    near_right = good && near_r_raw && !near_l_raw;
    chg        = good && have_lane && (s1_lane != last_lane);

    sum    = {1'b0, s1_left} + {1'b0, s1_right};
    mid    = BW'(sum >> 1);
    offset = $signed({1'b0, CC}) - $signed({1'b0, mid});

    n_left  = left_cnt;
    n_right = right_cnt;
    n_good  = good_cnt;
    n_bad   = bad_cnt;
    n_clr   = clr_cnt;
    if (s1_valid) begin
      n_left  = (near_left && !chg)  ? sat_inc(left_cnt)  : '0;
      n_right = (near_right && !chg) ? sat_inc(right_cnt) : '0;
      n_good  = good ? sat_inc(good_cnt) : '0;
      n_bad   = bad  ? sat_inc(bad_cnt)  : '0;
      if ((state == WARN_L && good && !near_left) || (state == WARN_R && good && !near_right))
        n_clr = sat_inc(clr_cnt);
      else
        n_clr = '0;
    end

    state_base = state;
    if (bad && n_bad == CF) begin
      state_base = LOST;
    end else if (good) begin
      case (state)
        IDLE:   state_base = TRACK;
        TRACK:  if (n_left == CF)       state_base = WARN_L;
                else if (n_right == CF) state_base = WARN_R;
        WARN_L,
        WARN_R: if (chg || n_clr == CF) state_base = TRACK;
        LOST:   if (n_good == CF)       state_base = TRACK;
        default: state_base = IDLE;
      endcase
    end

    // The watchdog arms as soon as tracking starts; a valid in the terminal cycle wins.
    counting   = (state != IDLE) || (state_base != IDLE);
    wd_hit     = counting && !dec.decision_out_valid && (wd_cnt == WD_LAST);
    state_next = (wd_hit && state != LOST) ? LOST : state_base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      left_cnt        <= '0;
      right_cnt       <= '0;
      good_cnt        <= '0;
      bad_cnt         <= '0;
      clr_cnt         <= '0;
      wd_cnt          <= '0;
      last_lane       <= '0;
      have_lane       <= 1'b0;
      lane_offset     <= '0;
      offset_valid    <= 1'b0;
      lane_change     <= 1'b0;
      departure_left  <= 1'b0;
      departure_right <= 1'b0;
      lane_lost       <= 1'b0;
      monitor_state   <= 3'd0;
    end else begin
      offset_valid <= good;
      lane_change  <= chg;
      if (good) begin
        lane_offset <= offset;
        last_lane   <= s1_lane;
        have_lane   <= 1'b1;
      end

      left_cnt  <= n_left;
      right_cnt <= n_right;
      good_cnt  <= n_good;
      bad_cnt   <= n_bad;
      clr_cnt   <= (state_next != state) ? '0 : n_clr;
      state     <= state_next;

      if (dec.decision_out_valid)
        wd_cnt <= '0;
      else if (counting && wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + WW'(1);

      departure_left  <= (state == WARN_L);
      departure_right <= (state == WARN_R);
      lane_lost       <= (state == LOST);
      monitor_state   <= state;
    end
  end

endmodule
